// File: rtl/css_subtractor_seq.sv
// css_subtractor_seq: 32-bit subtractor computed SLICE_W bits per cycle using borrow-select.
// Define CSS_FLAGS_EN to add the registered zero/ovf flag outputs.
module css_subtractor_seq #(
  parameter int SLICE_W = 8,
  parameter int NSLICE  = 32 / SLICE_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
`ifdef CSS_FLAGS_EN
  output logic        bout,
  output logic        zero,
  output logic        ovf
`else
  output logic        bout
`endif
);

  localparam int K_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                          state_reg, state_next;
  logic [NSLICE-1:0][SLICE_W-1:0]  a_reg, b_reg, diff_reg;
  logic [K_W-1:0]                  k_reg;
  logic                            borrow_reg, bout_reg;

  logic [SLICE_W-1:0]              a_slice, b_slice, sel_diff;
  logic [SLICE_W:0]                d0, d1;
  logic                            sel_borrow, accept, last_slice;

  assign last_slice = (k_reg == K_W'(NSLICE - 1));

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Both borrow-in candidates are formed every cycle; the registered borrow only picks one.
  always_comb begin
    a_slice    = a_reg[k_reg];
    b_slice    = b_reg[k_reg];
    d0         = {1'b0, a_slice} - {1'b0, b_slice};
    d1         = {1'b0, a_slice} - {1'b0, b_slice} - (SLICE_W + 1)'(1);
    sel_diff   = borrow_reg ? d1[SLICE_W-1:0] : d0[SLICE_W-1:0];
    sel_borrow = borrow_reg ? d1[SLICE_W]     : d0[SLICE_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      diff_reg   <= '0;
      k_reg      <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg      <= a;
        b_reg      <= b;
        borrow_reg <= bin;
        k_reg      <= '0;
      end else if (state_reg == BUSY) begin
        diff_reg[k_reg] <= sel_diff;
        borrow_reg      <= sel_borrow;
        k_reg           <= k_reg + 1'b1;
        if (last_slice) bout_reg <= sel_borrow;
      end
    end
  end

  assign diff = diff_reg;
  assign bout = bout_reg;

`ifdef CSS_FLAGS_EN
  logic                           zero_reg, ovf_reg;
  logic [NSLICE-1:0][SLICE_W-1:0] diff_final;

  // Full result as it will look after the top slice is written this cycle.
  always_comb begin
    diff_final         = diff_reg;
    diff_final[NSLICE-1] = sel_diff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (state_reg == BUSY && last_slice) begin
      zero_reg <= (diff_final == '0);
      ovf_reg  <= (a_reg[NSLICE-1][SLICE_W-1] != b_reg[NSLICE-1][SLICE_W-1]) &&
                  (diff_final[NSLICE-1][SLICE_W-1] != a_reg[NSLICE-1][SLICE_W-1]);
    end
  end

  assign zero = zero_reg;
  assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_css_subtractor_seq.sv
// Bench for css_subtractor_seq: arithmetic reference model checked every cycle plus directed literals.
// Flag checks are compiled in when CSS_FLAGS_EN is defined.
module tb_css_subtractor_seq;

  localparam int NSLICE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [31:0] a, b, diff;
`ifdef CSS_FLAGS_EN
  logic        zero, ovf;
`endif

  int checks = 0;
  int errors = 0;

  css_subtractor_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef CSS_FLAGS_EN
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
`else
    .bout      (bout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding operation, result due NSLICE edges after acceptance.
  logic        pending = 1'b0;
  int          since = 0;
  logic [31:0] m_diff;
  logic        m_bout, m_zero, m_ovf;

  always @(posedge clk) begin
    logic [32:0] full;
    if (rst) begin
      pending = 1'b0;
    end else if (pending) begin
      if (since >= NSLICE && out_ready) pending = 1'b0;
      else since++;
    end else if (in_valid) begin
      full    = {1'b0, a} - {1'b0, b} - {32'd0, bin};
      m_diff  = full[31:0];
      m_bout  = full[32];
      m_zero  = (full[31:0] == 32'd0);
      m_ovf   = (a[31] != b[31]) && (full[31] != a[31]);
      pending = 1'b1;
      since   = 0;
      $display("accept a=%h b=%h bin=%0d -> diff=%h bout=%0d", a, b, bin, m_diff, m_bout);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, !pending);
      chk("out_valid", out_valid, pending && since >= NSLICE);
      if (pending && since >= NSLICE) begin
        chk("diff", diff, m_diff);
        chk("bout", bout, m_bout);
`ifdef CSS_FLAGS_EN
        chk("zero", zero, m_zero);
        chk("ovf", ovf, m_ovf);
`endif
      end
    end
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin,
                        input logic [31:0] xd, input logic xb, input int hold, input bit lit);
    int n;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    // Garbage with in_valid still high: must be ignored while busy/done.
    a = ~ta; b = tb_ ^ 32'h00FF_00FF; bin = ~tbin;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (lit) begin
      chk("latency", n, NSLICE);
      chk("lit_diff", diff, xd);
      chk("lit_bout", bout, xb);
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1);
    $display("result diff=%h bout=%0d", diff, bout);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_out_valid", out_valid, 0);
`ifdef CSS_FLAGS_EN
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);

    run_op(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 0, 1);
`ifdef CSS_FLAGS_EN
    chk("v1_zero", zero, 0); chk("v1_ovf", ovf, 0);
`endif
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1, 1);
`ifdef CSS_FLAGS_EN
    chk("v2_zero", zero, 0); chk("v2_ovf", ovf, 0);
`endif
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 3, 1);
`ifdef CSS_FLAGS_EN
    chk("v3_zero", zero, 0); chk("v3_ovf", ovf, 1);
`endif
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 0, 1);
`ifdef CSS_FLAGS_EN
    chk("v4_zero", zero, 1); chk("v4_ovf", ovf, 0);
`endif
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 2, 1);
`ifdef CSS_FLAGS_EN
    chk("v5_zero", zero, 0); chk("v5_ovf", ovf, 0);
`endif

    // Reset right after slice 1 has been processed: pending result is discarded.
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h0101_0101; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    $display("mid-busy reset applied");

    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 32'hD2FF_CEE1, 1'b0, 1, 1);
`ifdef CSS_FLAGS_EN
    chk("v6_zero", zero, 0); chk("v6_ovf", ovf, 0);
`endif

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 32'd0, 1'b0, int'($urandom_range(0, 2)), 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/css_subtractor_seq.md
CSS_SUBTRACTOR_SEQ -- requirements
Module: css_subtractor_seq

Interface
REQ-001 SHALL have parameter SLICE_W, default 8, slice width in bits; legal values 4, 8, 16.
REQ-002 SHALL have parameter NSLICE, default 32/SLICE_W, slice count; derived only, never overridden.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  32  minuend, unsigned or two's complement.
REQ-008 SHALL have port b  input  32  subtrahend.
REQ-009 SHALL have port bin  input  1  borrow-in.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port diff  output  32  registered a - b - bin, modulo 2^32.
REQ-013 SHALL have port bout  output  1  borrow-out: 1 iff a < b + bin, unsigned.
REQ-014 SHALL have ports zero and ovf, each output 1, present only under CSS_FLAGS_EN (REQ-032).

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 SHALL accept on a clk edge with in_valid && in_ready, capture a, b, bin into internal registers, clear slice counter k, and go IDLE -> BUSY.
REQ-018 SHALL, on each BUSY edge, process slice k (bits k*SLICE_W+SLICE_W-1 : k*SLICE_W) and increment k.
REQ-019 SHALL compute both slice differences each BUSY cycle, one for borrow-in 0 and one for borrow-in 1, and select by the registered running borrow (borrow-select; no ripple between slices within a cycle).
REQ-020 SHALL initialise the running borrow to captured bin; after each slice, set it to the selected slice borrow-out.
REQ-021 SHALL go BUSY -> DONE on the edge that processes slice NSLICE-1; out_valid rises exactly NSLICE edges after the accepting edge (4 at default).
REQ-022 SHALL hold diff, bout and flags stable throughout DONE until out_valid && out_ready, then go DONE -> IDLE on that edge.
REQ-023 SHALL ignore in_valid, a, b and bin in BUSY and DONE; operand changes after acceptance do not affect the result.
REQ-024 SHALL retain diff/bout/flags of the last result while in IDLE and BUSY; diff is updated slice-by-slice only in BUSY and is valid only when out_valid = 1.
REQ-025 SHALL allow back-to-back operation: a new accept occurs no earlier than the edge after the output handshake (throughput one result per NSLICE+2 cycles).
REQ-026 SHALL compute bout as the final running borrow; wrap-around cases (e.g. 0 - 1) yield diff = 0xFFFF_FFFF, bout = 1.

Reset
REQ-027 SHALL, on any edge with rst = 1, enter IDLE regardless of state, including mid-BUSY and in DONE with a pending result, which is discarded.
REQ-028 SHALL reset diff = 0, bout = 0, k = 0, running borrow = 0, zero = 0, ovf = 0, out_valid = 0.
REQ-029 SHALL assert in_ready = 1 in the first cycle after rst deasserts.
REQ-030 SHALL give rst priority over any simultaneous in or out handshake.

Configuration
REQ-031 SHALL compile the flag logic in only when macro CSS_FLAGS_EN is defined.
REQ-032 SHALL, with CSS_FLAGS_EN, provide zero = (diff == 0) and ovf = (a[31] != b[31]) && (diff[31] != a[31]) on captured operands, both registered, valid with out_valid.
REQ-033 SHALL, without CSS_FLAGS_EN, omit the zero and ovf ports and logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover: a=0x0001_0000, b=0x0000_0001, bin=0 -> diff=0x0000_FFFF, bout=0; out_valid high 4 edges after accept; borrow crosses slice boundaries.
REQ-035 SHALL cover: a=0, b=1, bin=0 -> diff=0xFFFF_FFFF, bout=1, ovf=0, zero=0.
REQ-036 SHALL cover: a=0x8000_0000, b=1, bin=0 -> diff=0x7FFF_FFFF, bout=0, ovf=1.
REQ-037 SHALL cover: a=b=0x1234_5678 with bin=0 -> diff=0, zero=1; then with bin=1 -> diff=0xFFFF_FFFF, bout=1.
REQ-038 SHALL cover: out_ready held low 3 cycles in DONE with in_valid=1 -> out_valid, diff, bout stable; in_ready=0; no new accept until the edge after the out_ready handshake.
REQ-039 SHALL cover: rst pulsed in the cycle after slice 1 is processed -> next cycle IDLE, in_ready=1, out_valid=0, diff=0; a new operation then completes correctly.
